div_tick_sched: RTL and testbench
=================================

# div_tick_sched

Synchronous clock-enable scheduler for the divider subsystem. It replaces ripple-clocked division with single-clock tick enables: NCH independent channels, each with a programmable divide ratio, loaded through a valid/ready configuration port and re-phased together by a global sync strobe. Downstream logic stays on `clk` and qualifies its updates with `tick[i]`.

## Interface
- `NCH`, 4: number of tick channels (1..8)
- `DW`, 8: divisor width in bits
- `clk` in 1: sole clock
- `reset` in 1: reset, synchronous, active-high; clock clk
- `cfg_valid` in 1: configuration request
- `cfg_ready` out 1: configuration port can accept
- `cfg_ch` in $clog2(NCH) (min 1): target channel
- `cfg_div` in DW: divisor d; channel period = d+1 cycles
- `cfg_en` in 1: 1 enables channel, 0 disables it
- `sync` in 1: restart all enabled channels in phase
- `tick` out NCH: one-cycle enable pulses, registered
- `active` out NCH: per-channel enable state
- `sq` out NCH: square-wave outputs (only with `DIV_SQUARE_OUT_EN`)

## Operation
- Config FSM, two states:
  - IDLE: `cfg_ready`=1; `cfg_valid`&&`cfg_ready` at an edge captures ch/div/en and moves to APPLY.
  - APPLY: `cfg_ready`=0; at the next edge writes `div[ch]`, `en[ch]`, `cnt[ch]<=cfg_div`, returns to IDLE.
  - Max throughput: one config per 2 cycles.
- Per channel, per edge:
  - `en`=0: `cnt` holds; `tick`=0.
  - `en`=1, `cnt`!=0: `cnt<=cnt-1`; `tick`=0.
  - `en`=1, `cnt`==0: `cnt<=div`; `tick`=1.
- `sync`=1: every enabled channel loads `cnt<=div`; `tick`=0 that edge.
- Same-edge priority: reset > APPLY write > sync > count. The APPLY write to channel `ch` overrides sync for that channel; other channels still re-phase.
- Disabling a channel drops `tick` at the write edge. Pending count is discarded.
- `cfg_ch` >= NCH: handshake completes, write is ignored.
- Unsigned arithmetic throughout. `d`=0 gives `tick` high every cycle. `d`=2^DW-1 gives period 2^DW.

## Timing
- Reset values:
  - `cfg_ready`=0; rises on the first edge with `reset`=0.
  - FSM=IDLE; `tick`=0, `active`=0, `sq`=0.
  - All `div` and `cnt` registers = 0.
- Reset mid-APPLY aborts the write.
- Handshake accepted at edge E0, write at E1. With `en`=1, the first `tick` is high after edge E1+d+1, then every d+1 cycles.
- `active[ch]` updates at E1.
- `sync` at edge S: first tick after edge S+d+1.
- `tick` is registered and glitch-free. Downstream must treat it as an enable only, never as a clock.

## Configuration
- `DIV_SQUARE_OUT_EN` defined: per-channel toggle flop.
  - `sq[i]` inverts on every edge where `tick[i]` becomes 1, giving a 50%-duty square wave of period 2(d+1).
  - `sq` is cleared on reset, on disable, and on sync.
- `DIV_SQUARE_OUT_EN` undefined: `sq` port and toggle flops are absent. Tick behaviour is identical.

## Structure
- Package `div_sched_pkg`:
  - FSM state enum (IDLE, APPLY)
  - default `NCH`/`DW` constants
  - channel-index width function
- Sub-module `div_sched_chan`: one channel (`div`, `en`, `cnt`, `tick`, optional `sq`).
  - Inputs: `load`, `load_div`, `load_en`, `sync`.
  - Instantiated NCH times by generate.
- Top level holds the config FSM and decode.

## Test plan
- Reset: hold `reset` 3 cycles → `tick`=0, `active`=0, `cfg_ready`=0; `cfg_ready`=1 one cycle after release.
- Config ch0 d=3 en=1 → `cfg_ready` low 1 cycle; `active[0]`=1 at E1; `tick[0]` first high after E5, then period 4, pulse width 1.
- Config ch1 d=0 and ch2 d=1 back-to-back with `cfg_valid` held → second accept 2 cycles after first; `tick[1]` continuous high, `tick[2]` alternates.
- With ch0 d=3 and ch2 d=1 running, pulse `sync` → both ticks low at S; next ticks after S+4 and S+2, phase-aligned.
- APPLY to ch0 (d=5) on the same edge as `sync` → ch0 uses d=5, ch2 re-phases with d=1; then disable ch0 mid-count → `tick[0]` never fires again.
- With `DIV_SQUARE_OUT_EN`, ch3 d=1 → `sq[3]` period 4, 50% duty; reset mid-APPLY → no write, `active[3]`=0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types, defaults and helpers for the tick scheduler
package div_sched_pkg;
  localparam int NCH_DEF = 4;
  localparam int DW_DEF = 8;
  typedef enum logic {IDLE, APPLY} cfg_state_e;
  function automatic int chw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/div_sched_chan.sv
// div_sched_chan: one tick channel with reloadable down-counter; sq_o only with DIV_SQUARE_OUT_EN
module div_sched_chan #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [DW-1:0] load_div_i,
  input  logic          load_en_i,
  input  logic          sync_i,
  output logic          tick_o,
  output logic          active_o
`ifdef DIV_SQUARE_OUT_EN
  , output logic        sq_o
`endif
);
  logic [DW-1:0] div_q, cnt_q;
  logic          en_q, tick_q, wrap;
  assign wrap = cnt_q == '0;
  assign tick_o = tick_q;
  assign active_o = en_q;
  // config write beats sync, sync beats normal counting; a wrap reloads and fires the tick
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      en_q   <= 1'b0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (load_i) begin
      div_q  <= load_div_i;
      en_q   <= load_en_i;
      cnt_q  <= load_div_i;
      tick_q <= 1'b0;
    end else if (sync_i && en_q) begin
      cnt_q  <= div_q;
      tick_q <= 1'b0;
    end else if (en_q) begin
      cnt_q  <= wrap ? div_q : cnt_q - DW'(1);
      tick_q <= wrap;
    end else begin
      tick_q <= 1'b0;
    end
  end
`ifdef DIV_SQUARE_OUT_EN
  logic sq_q;
  assign sq_o = sq_q;
  // toggle on each tick so the square wave has period 2(d+1); any re-phase clears it
  always_ff @(posedge clk) begin
    if (reset || load_i || (sync_i && en_q))
      sq_q <= 1'b0;
    else if (en_q && wrap)
      sq_q <= ~sq_q;
  end
`endif
endmodule

// File: rtl/div_tick_sched.sv
// div_tick_sched: NCH clock-enable tick channels with valid/ready config and global sync; DIV_SQUARE_OUT_EN adds sq
module div_tick_sched
  import div_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  localparam int CW = chw(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  input  logic           cfg_en,
  input  logic           sync,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] active
`ifdef DIV_SQUARE_OUT_EN
  , output logic [NCH-1:0] sq
`endif
);
  cfg_state_e    state_q;
  logic          ready_q, en_q;
  logic [CW-1:0] ch_q;
  logic [DW-1:0] div_q;
  assign cfg_ready = ready_q;
  // two-state config FSM: capture in IDLE, write one cycle later in APPLY
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      ch_q    <= '0;
      div_q   <= '0;
      en_q    <= 1'b0;
    end else if (state_q == APPLY) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
    end else if (cfg_valid && ready_q) begin
      state_q <= APPLY;
      ready_q <= 1'b0;
      ch_q    <= cfg_ch;
      div_q   <= cfg_div;
      en_q    <= cfg_en;
    end else begin
      ready_q <= 1'b1;
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    div_sched_chan #(.DW(DW)) u_chan (
      .clk        (clk),
      .reset      (reset),
      .load_i     (state_q == APPLY && ch_q == CW'(i)),
      .load_div_i (div_q),
      .load_en_i  (en_q),
      .sync_i     (sync),
      .tick_o     (tick[i]),
      .active_o   (active[i])
`ifdef DIV_SQUARE_OUT_EN
      , .sq_o     (sq[i])
`endif
    );
  end
endmodule

// File: tb/tb_div_tick_sched.sv
// tb_div_tick_sched: directed self-checking bench for div_tick_sched
module tb_div_tick_sched;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_en = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] tick, active;
`ifdef DIV_SQUARE_OUT_EN
  logic [3:0] sq;
`endif
  int n_chk = 0;
  int n_fail = 0;

  div_tick_sched #(.NCH(4), .DW(8)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .sync(sync),
    .tick(tick), .active(active)
`ifdef DIV_SQUARE_OUT_EN
    , .sq(sq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n, input int ch, output logic [31:0] p);
    p = '0;
    repeat (n) begin
      step();
      p = {p[30:0], tick[ch]};
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] d, input logic en);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_div = d; cfg_en = en;
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] p, q, r;
    int cnt;
    repeat (3) step();
    check("rst_tick", tick, 0);
    check("rst_active", active, 0);
    check("rst_ready", cfg_ready, 0);
    reset = 1'b0;
    step();
    check("ready_after_rst", cfg_ready, 1);

    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; cfg_en = 1'b1;
    step();
    check("ready_low_apply", cfg_ready, 0);
    cfg_valid = 1'b0;
    step();
    check("ch0_active_e1", active, 4'b0001);
    check("ready_back", cfg_ready, 1);
    check("ch0_tick_e1", tick[0], 0);
    collect(8, 0, p);
    check("ch0_d3_pattern", p, 32'b0001_0001);

    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0; cfg_en = 1'b1;
    step();
    check("b2b_first_busy", cfg_ready, 0);
    cfg_ch = 2'd2; cfg_div = 8'd1;
    step();
    check("b2b_ready_again", cfg_ready, 1);
    step();
    check("b2b_second_busy", cfg_ready, 0);
    cfg_valid = 1'b0;
    step();
    check("b2b_active", active, 4'b0111);
    p = '0; q = '0;
    repeat (4) begin
      step();
      p = {p[30:0], tick[1]};
      q = {q[30:0], tick[2]};
    end
    check("ch1_d0_cont", p, 4'b1111);
    check("ch2_d1_alt", q, 4'b0101);

    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_ticks_low", tick, 0);
    p = '0; q = '0; r = '0;
    repeat (4) begin
      step();
      p = {p[30:0], tick[0]};
      q = {q[30:0], tick[2]};
      r = {r[30:0], tick[1]};
    end
    check("sync_ch0", p, 4'b0001);
    check("sync_ch2", q, 4'b0101);
    check("sync_ch1", r, 4'b1111);

    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5; cfg_en = 1'b1;
    step();
    cfg_valid = 1'b0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("apply_sync_low", tick, 0);
    p = '0; q = '0;
    repeat (6) begin
      step();
      p = {p[30:0], tick[0]};
      q = {q[30:0], tick[2]};
    end
    check("apply_sync_ch0_d5", p, 6'b000001);
    check("apply_sync_ch2", q, 6'b010101);
    repeat (2) step();
    cfg(2'd0, 8'd5, 1'b0);
    check("disable_active", active, 4'b0110);
    check("disable_tick_drop", tick[0], 0);
    p = '0;
    repeat (12) begin
      step();
      p[0] = p[0] | tick[0];
    end
    check("disabled_silent", p[0], 0);

    cfg(2'd3, 8'd255, 1'b1);
    cnt = 0;
    do begin step(); cnt++; end while (!tick[3] && cnt < 600);
    check("d255_first", cnt, 256);
    cnt = 0;
    do begin step(); cnt++; end while (!tick[3] && cnt < 600);
    check("d255_period", cnt, 256);

`ifdef DIV_SQUARE_OUT_EN
    cfg(2'd3, 8'd1, 1'b1);
    check("sq_cleared", sq[3], 0);
    p = '0;
    repeat (6) begin
      step();
      p = {p[30:0], sq[3]};
    end
    check("sq3_wave", p, 6'b011001);
`endif

    cfg(2'd3, 8'd0, 1'b0);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd2; cfg_en = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_valid = 1'b0;
    step();
    check("rst_mid_apply_active", active, 0);
    check("rst_mid_apply_ready", cfg_ready, 1);
    step();
    check("rst_mid_apply_noact", active[3], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
